// File: rtl/serial_addsub_digit.sv
// Digit-serial add/subtract unit: one DIGIT_W-bit digit per valid beat, LS digit first,
// words delimited by last or forcibly ended after MAX_BEATS beats.
// Registered result stream with per-word carry, signed-overflow and timeout flags.
// Optional: define SERIAL_ADDSUB_ZERO_FLAG_EN to add the out_zero word-is-zero flag.
module serial_addsub_digit #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_err
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  , output logic             out_zero
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS);
  localparam int unsigned SUM_W = DIGIT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic               w_mode_nxt;
  logic               w_carry_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_mode;
  logic               w_cin;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [SUM_W-1:0]   w_full;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_c_msb;
  logic               w_term;

  logic               w_out_vld_nxt;
  logic [DIGIT_W-1:0] w_sum_nxt;
  logic               w_out_last_nxt;
  logic               w_out_carry_nxt;
  logic               w_out_ovf_nxt;
  logic               w_out_err_nxt;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic               r_nz;
  logic               w_nz_nxt;
  logic               w_out_zero_nxt;
`endif

  // Beat arithmetic: first beat of a word takes mode and carry-in from sub
  always_comb begin
    w_mode  = (r_state == ST_FIRST) ? sub : r_mode;
    w_cin   = (r_state == ST_FIRST) ? sub : r_carry;
    w_b_eff = w_mode ? ~b : b;
    w_full  = SUM_W'(a) + SUM_W'(w_b_eff) + SUM_W'(w_cin);
    w_s     = w_full[DIGIT_W-1:0];
    w_c     = w_full[DIGIT_W];
    // carry into the MSB recovered from the MSB sum bit and its operands
    w_c_msb = w_s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];
    w_term  = vld & (last | (r_cnt == CNT_MAX));
  end

  // Next-state and next-output logic for the word FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_carry_nxt     = r_carry;
    w_cnt_nxt       = r_cnt;
    w_out_vld_nxt   = vld;
    w_sum_nxt       = sum;
    w_out_last_nxt  = 1'b0;
    w_out_carry_nxt = 1'b0;
    w_out_ovf_nxt   = 1'b0;
    w_out_err_nxt   = 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    w_nz_nxt        = r_nz;
    w_out_zero_nxt  = 1'b0;
`endif
    if (vld) begin
      w_sum_nxt = w_s;
      if (r_state == ST_FIRST) begin
        w_mode_nxt = sub;
      end
      if (w_term) begin
        w_state_nxt     = ST_FIRST;
        w_carry_nxt     = 1'b0;
        w_cnt_nxt       = '0;
        w_out_last_nxt  = 1'b1;
        w_out_carry_nxt = w_c;
        w_out_ovf_nxt   = w_c_msb ^ w_c;
        w_out_err_nxt   = ~last;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        w_nz_nxt        = 1'b0;
        w_out_zero_nxt  = ~(r_nz | (|w_s));
`endif
      end else begin
        w_state_nxt = ST_MID;
        w_carry_nxt = w_c;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        w_nz_nxt    = r_nz | (|w_s);
`endif
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= 1'b0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      out_vld   <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_carry   <= w_carry_nxt;
      r_cnt     <= w_cnt_nxt;
      out_vld   <= w_out_vld_nxt;
      sum       <= w_sum_nxt;
      out_last  <= w_out_last_nxt;
      out_carry <= w_out_carry_nxt;
      out_ovf   <= w_out_ovf_nxt;
      out_err   <= w_out_err_nxt;
    end
  end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  // Sticky nonzero tracker and word-is-zero flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nz     <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      r_nz     <= w_nz_nxt;
      out_zero <= w_out_zero_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit (DIGIT_W=4, MAX_BEATS=4) with a result scoreboard.
module tb_serial_addsub_digit;

  logic       clk;
  logic       rst;
  logic       vld;
  logic [3:0] a;
  logic [3:0] b;
  logic       sub;
  logic       last;
  logic       out_vld;
  logic [3:0] sum;
  logic       out_last;
  logic       out_carry;
  logic       out_ovf;
  logic       out_err;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int total = 0;
  int bad   = 0;
  string step = "init";

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       l;
    logic       c;
    logic       o;
    logic       e;
    logic       z;
  } exp_t;

  exp_t sb[$];

  serial_addsub_digit #(.DIGIT_W(4), .MAX_BEATS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .last     (last),
    .out_vld  (out_vld),
    .sum      (sum),
    .out_last (out_last),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_err  (out_err)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", step, tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [3:0] s, input logic l,
                              input logic c, input logic o, input logic e, input logic z);
    exp_t r;
    r.v = v; r.s = s; r.l = l; r.c = c; r.o = o; r.e = e; r.z = z;
    return r;
  endfunction

  task automatic check_pop();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s.sb_empty observed=0 expected=1", step);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_vld", 4'(out_vld), 4'(e.v));
      if (e.v) chk("sum", sum, e.s);
      chk("out_last", 4'(out_last), 4'(e.l));
      chk("out_carry", 4'(out_carry), 4'(e.c));
      chk("out_ovf", 4'(out_ovf), 4'(e.o));
      chk("out_err", 4'(out_err), 4'(e.e));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      chk("out_zero", 4'(out_zero), 4'(e.z));
`endif
    end
  endtask

  // Drive one cycle of inputs, expect the given result one edge later
  task automatic cyc(input logic v, input logic [3:0] da, input logic [3:0] db,
                     input logic ds, input logic dl, input exp_t e);
    vld = v; a = da; b = db; sub = ds; last = dl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic idle(input logic ds, input logic dl);
    cyc(1'b0, 4'h0, 4'h0, ds, dl, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic chk_all_zero();
    chk("out_vld", 4'(out_vld), 4'h0);
    chk("sum", sum, 4'h0);
    chk("out_last", 4'(out_last), 4'h0);
    chk("out_carry", 4'(out_carry), 4'h0);
    chk("out_ovf", 4'(out_ovf), 4'h0);
    chk("out_err", 4'(out_err), 4'h0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    chk("out_zero", 4'(out_zero), 4'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; a = '0; b = '0; sub = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step = "reset";
    chk_all_zero();
    rst = 1'b0;
    idle(1'b0, 1'b0);

    // 0x3C + 0x25 = 0x61
    step = "add";
    cyc(1'b1, 4'hC, 4'h5, 1'b0, 1'b0, mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'h3, 4'h2, 1'b0, 1'b1, mk(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // 0x25 - 0x3C = 0xE9 with borrow, sub toggled during bubbles
    step = "sub_bubble";
    cyc(1'b1, 4'h5, 4'hC, 1'b1, 1'b0, mk(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    cyc(1'b1, 4'h2, 4'h3, 1'b0, 1'b1, mk(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // 0x70 + 0x10 = 0x80 signed overflow
    step = "ovf";
    cyc(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'h7, 4'h1, 1'b0, 1'b1, mk(1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

    // 0xFF + 0x01 = 0x00 with carry out, all-zero word
    step = "carry";
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b1, mk(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));

    // last without vld is ignored: 0x12 + 0x34 = 0x46
    step = "ign_last";
    cyc(1'b1, 4'h2, 4'h4, 1'b0, 1'b0, mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b0, 1'b1);
    cyc(1'b1, 4'h1, 4'h3, 1'b0, 1'b1, mk(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // single-beat word 7 + 1 = 8, overflow
    step = "single";
    cyc(1'b1, 4'h7, 4'h1, 1'b0, 1'b1, mk(1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

    // timeout: 4 beats of F+0 without last
    step = "timeout";
    cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    // fresh word takes mode from sub: 5 - 3 = 2, no borrow
    step = "after_timeout";
    cyc(1'b1, 4'h5, 4'h3, 1'b1, 1'b1, mk(1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    // timeout with carry chain: stored carry must clear at forced word end
    step = "timeout_carry";
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    cyc(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // reset mid-word: 9+9 leaves carry, async reset clears everything
    step = "rst_mid";
    cyc(1'b1, 4'h9, 4'h9, 1'b0, 1'b0, mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vld = 1'b0; last = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step = "after_rst";
    chk_all_zero();
    cyc(1'b1, 4'h1, 4'h2, 1'b0, 1'b0, mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 4'h1, 4'h2, 1'b0, 1'b1, mk(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step = "tail";
    idle(1'b0, 1'b0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Digit-serial add/subtract unit: one DIGIT_W-bit digit per valid beat, least-significant digit first, words of arbitrary length delimited by last.
- Parametrised successor of the 1-bit serial adder. Adds:
  - a per-word add/subtract mode;
  - a registered output stream with valid/last;
  - carry and signed-overflow flags;
  - a beat-count guard.
- Sits between serial operand sources and a serial result consumer in the sequential-basics datapath.

Parameters:
- DIGIT_W, 4, bits per beat (>=1).
- MAX_BEATS, 16, max beats per word (>=2); counter width is $clog2(MAX_BEATS).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- vld  input  1  input beat valid
- a  input  DIGIT_W  operand A digit
- b  input  DIGIT_W  operand B digit
- sub  input  1  mode, sampled on first beat of a word only: 0=A+B, 1=A-B
- last  input  1  final beat of word; honoured only with vld
- out_vld  output  1  result beat valid
- sum  output  DIGIT_W  result digit
- out_last  output  1  final result beat of word
- out_carry  output  1  raw carry out of word MSB; valid with out_last, else 0
- out_ovf  output  1  signed (two's complement) overflow; valid with out_last, else 0
- out_err  output  1  word forcibly terminated at MAX_BEATS; valid with out_last, else 0

Behaviour:
- Reset: one clock, asynchronous active-high.
  - All outputs 0.
  - Carry 0, beat counter 0, latched mode 0, state FIRST.
- Latency: exactly 1 cycle. A beat accepted at edge N appears on the outputs after edge N; outputs are registered.
- out_vld follows vld one cycle later. With vld=0 the outputs drop to 0 (out_vld=0, flags 0); sum holds its last value and is don't-care.
- Word state (2 states):
  - FIRST:
    - Beat uses mode m=sub and carry_in=sub; sub is latched.
    - If the beat is not terminating, go to MID.
  - MID:
    - Beat uses the latched mode and the stored carry.
    - A terminating beat returns to FIRST.
- Arithmetic per beat: {c, s} = a + (m ? ~b : b) + carry_in, in DIGIT_W+1 bits. sum <= s; stored carry <= c.
- Terminating beat: vld & (last | beat_cnt == MAX_BEATS-1).
  - out_last <= 1.
  - out_carry <= c. In subtract mode 1 means no borrow.
  - out_ovf <= carry into digit bit DIGIT_W-1 XOR c.
  - out_err <= ~last.
  - Carry and beat_cnt clear; state returns to FIRST.
- A single-beat word (FIRST with last) is legal. Mode and carry-in are both taken from sub on that beat.
- last with vld=0 is ignored. sub outside FIRST is ignored.
- beat_cnt increments on each non-terminating valid beat and never wraps past MAX_BEATS-1.
- Bubbles (vld=0) between beats of a word preserve carry, count and mode.
- rst mid-word aborts the word. No out_last is emitted for it. The next valid beat starts a new word.

Optional Feature:
- Macro: SERIAL_ADDSUB_ZERO_FLAG_EN.
- With the macro defined: adds output port out_zero (1 bit, reset 0).
  - An internal sticky OR of all result digits of the current word is kept. It clears at word end and on rst.
  - out_zero <= 1 on the terminating beat when every digit of the word, including the last, was zero. Otherwise out_zero is 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Test Plan (DIGIT_W=4 unless noted; digits listed LS-first):
- Add: a=0x3C, b=0x25, sub=0, 2 beats, last on beat 2 -> sum C+5 -> 0x1 then 0x6 (0x61); out_last on beat 2, out_carry=0, out_ovf=0, out_err=0.
- Subtract with bubbles: a=0x25, b=0x3C, sub=1 on beat 1, vld low 3 cycles between beats, sub toggled during the bubble -> digits 0x9, 0xE (0xE9); out_carry=0 (borrow); out_ovf=0.
- Overflow: a=0x70, b=0x10, sub=0 -> 0x80, out_ovf=1, out_carry=0. Then a=0xFF, b=0x01 -> 0x00, out_carry=1, out_ovf=0 (out_zero=1 when the feature is enabled).
- Ignored last and single beat:
  - last=1 with vld=0 mid-word -> no out_last; the word completes normally later.
  - Single beat a=0x7, b=0x1, sub=0, last=1 -> sum 0x8, out_ovf=1.
- Timeout (MAX_BEATS=4): 4 valid beats of a=0xF, b=0x0, last never high -> out_last and out_err=1 on beat 4; the next beat starts a fresh word with carry 0.
- Reset mid-word: assert rst asynchronously between edges after beat 1 -> outputs immediately 0. A new 2-beat add of 0x11+0x22 -> 0x33 with no residual carry.
